// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC register with a direct-mapped BTB and 2-bit saturating counters.
// Presents the fetch PC and instruction, plus a taken/not-taken prediction and target.
module fetch_pc_predictor #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStallF,
    input  logic [31:0] iInstrMem,
    input  logic        iUpdateE,
    input  logic [31:0] iPCE,
    input  logic [31:0] iTargetE,
    input  logic        iTakenE,
    input  logic        iRedirectE,
    output logic [31:0] oPCF,
    output logic [31:0] oInstructionF,
    output logic        oTakeJBF,
    output logic [31:0] oPredTargetF
);

    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = 32 - BTB_IDX_W - 2;

    logic [31:0]                      pc_q, pc_d;
    logic [ENTRIES-1:0]               valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]    tag_q, tag_d;
    logic [ENTRIES-1:0][31:0]         target_q, target_d;
    logic [ENTRIES-1:0][1:0]          cnt_q, cnt_d;

    logic [BTB_IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]     lk_tag, up_tag;
    logic                 lk_hit, up_hit, take;
    logic [31:0]          pred_target;

    always_comb begin
        lk_idx      = pc_q[BTB_IDX_W+1:2];
        lk_tag      = pc_q[31:BTB_IDX_W+2];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        take        = lk_hit && cnt_q[lk_idx][1];
        pred_target = take ? target_q[lk_idx] : pc_q + 32'd4;
    end

    // Training: misses allocate only on taken outcomes; hits move the counter.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        up_idx   = iPCE[BTB_IDX_W+1:2];
        up_tag   = iPCE[31:BTB_IDX_W+2];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (iUpdateE) begin
            if (up_hit) begin
                if (iTakenE) begin
                    target_d[up_idx] = iTargetE;
                    if (cnt_q[up_idx] != 2'b11) begin
                        cnt_d[up_idx] = cnt_q[up_idx] + 2'd1;
                    end
                end else if (cnt_q[up_idx] != 2'b00) begin
                    cnt_d[up_idx] = cnt_q[up_idx] - 2'd1;
                end
            end else if (iTakenE) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = iTargetE;
                cnt_d[up_idx]    = 2'b10;
            end
        end
    end

    // A redirect from Execute wins over a stall so mispredictions always recover.
    always_comb begin
        pc_d = pred_target;
        if (iRedirectE) begin
            pc_d = iTakenE ? iTargetE : iPCE + 32'd4;
        end else if (iStallF) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            pc_q     <= RESET_PC;
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            cnt_q    <= {ENTRIES{2'b01}};
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    assign oPCF          = pc_q;
    assign oInstructionF = iInstrMem;
    assign oTakeJBF      = take;
    assign oPredTargetF  = pred_target;

endmodule
